// File: rtl/div36x18_if.sv
// Operand/result handshake bundle for div36x18_seq; in_signed exists only
// when DIV36X18_SIGNED_SEL_EN is defined.
interface div36x18_if;
  logic        in_valid;
  logic        in_ready;
  logic [35:0] dividend;
  logic [17:0] divisor;
`ifdef DIV36X18_SIGNED_SEL_EN
  logic        in_signed;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [17:0] quot;
  logic [17:0] rem;
  logic        ovf;
  logic        dz;

  modport master (
    output in_valid, dividend, divisor, out_ready,
`ifdef DIV36X18_SIGNED_SEL_EN
    output in_signed,
`endif
    input  in_ready, out_valid, quot, rem, ovf, dz
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
`ifdef DIV36X18_SIGNED_SEL_EN
    input  in_signed,
`endif
    output in_ready, out_valid, quot, rem, ovf, dz
  );
endinterface

// File: rtl/div36x18_seq.sv
// Iterative restoring divider, 36b / 18b -> 18b quotient + remainder, signed (C semantics).
// Define DIV36X18_SIGNED_SEL_EN to add bus.in_signed selecting unsigned operation per request.
module div36x18_seq #(
  parameter logic [17:0] DZ_QUOT = 18'h3FFFF,
  parameter bit          SAT     = 1'b1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     en,
  div36x18_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  r_state;
  logic [4:0]  r_cnt;
  logic [18:0] r_pr;
  logic [17:0] r_dq;
  logic [17:0] r_dv;
  logic [17:0] r_dd_lo;
  logic        r_dd_neg;
  logic        r_q_neg;
  logic        r_sgn;
  logic        r_wide;
  logic        r_out_valid;
  logic [17:0] r_quot;
  logic [17:0] r_rem;
  logic        r_ovf;
  logic        r_dz;

  logic        w_signed;
  logic        w_dd_neg;
  logic        w_dv_neg;
  logic [35:0] w_dd_mag;
  logic [17:0] w_dv_mag;
  logic [18:0] w_sh;
  logic [18:0] w_diff;
  logic        w_ge;
  logic        w_accept;
  logic        w_dz;
  logic        w_ovf;
  logic [17:0] w_quot;
  logic [17:0] w_rem;

`ifdef DIV36X18_SIGNED_SEL_EN
  assign w_signed = bus.in_signed;
`else
  assign w_signed = 1'b1;
`endif

  assign w_dd_neg = w_signed & bus.dividend[35];
  assign w_dv_neg = w_signed & bus.divisor[17];
  // -2^35 negates to 2^35, which is representable as a 36-bit unsigned magnitude.
  assign w_dd_mag = w_dd_neg ? -bus.dividend : bus.dividend;
  assign w_dv_mag = w_dv_neg ? -bus.divisor  : bus.divisor;
  assign w_accept = en & bus.in_valid & (r_state == S_IDLE);

  assign w_sh   = {r_pr[17:0], r_dq[17]};
  assign w_diff = w_sh - {1'b0, r_dv};
  assign w_ge   = (w_sh >= {1'b0, r_dv});

  // r_wide means the quotient magnitude needs more than 18 bits, so the 18 iterations
  // only yield an exact magnitude when it is clear; -2^17 is then the one legal 2^17.
  assign w_dz  = (r_dv == 18'd0);
  assign w_ovf = r_wide | (r_sgn & (r_q_neg ? (r_dq > 18'h20000) : (r_dq > 18'h1FFFF)));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_quot = r_q_neg ? -r_dq : r_dq;
    w_rem  = r_dd_neg ? -r_pr[17:0] : r_pr[17:0];
    if (w_dz) begin
      w_quot = DZ_QUOT;
      w_rem  = r_dd_lo;
    end else if (w_ovf && SAT) begin
      w_quot = !r_sgn ? 18'h3FFFF : (r_q_neg ? 18'h20000 : 18'h1FFFF);
      w_rem  = 18'd0;
    end
  end

  // NOTE: datapath registers carry no reset; the FSM never consumes them before an accept loads them.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_pr     <= {1'b0, w_dd_mag[35:18]};
      r_dq     <= w_dd_mag[17:0];
      r_dv     <= w_dv_mag;
      r_dd_lo  <= bus.dividend[17:0];
      r_dd_neg <= w_dd_neg;
      r_q_neg  <= w_dd_neg ^ w_dv_neg;
      r_sgn    <= w_signed;
      r_wide   <= (w_dd_mag[35:18] >= w_dv_mag);
      r_cnt    <= 5'd17;
    end else if (en && r_state == S_CALC) begin
      r_pr  <= w_ge ? w_diff : w_sh;
      r_dq  <= {r_dq[16:0], w_ge};
      r_cnt <= r_cnt - 5'd1;
    end
  end

  // FIX loads the result; the first DONE cycle raises out_valid, giving a fixed 20-cycle latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_quot      <= 18'd0;
      r_rem       <= 18'd0;
      r_ovf       <= 1'b0;
      r_dz        <= 1'b0;
    end else if (en) begin
      case (r_state)
        S_IDLE: if (bus.in_valid) r_state <= S_CALC;
        S_CALC: if (r_cnt == 5'd0) r_state <= S_FIX;
        S_FIX: begin
          r_quot  <= w_quot;
          r_rem   <= w_rem;
          r_ovf   <= w_ovf & ~w_dz;
          r_dz    <= w_dz;
          r_state <= S_DONE;
        end
        default: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.quot      = r_quot;
  assign bus.rem       = r_rem;
  assign bus.ovf       = r_ovf;
  assign bus.dz        = r_dz;

endmodule

// File: tb/tb_div36x18_seq.sv
// Self-checking bench for div36x18_seq: directed corner cases plus randomized operands
// compared against an integer-arithmetic reference model.
module tb_div36x18_seq;
  logic clk = 1'b0;
  logic rst_n;
  logic en;
  int   checks = 0;
  int   errors = 0;

  div36x18_if bus();

  div36x18_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit integer division, which truncates toward zero like C.
  function automatic void model(input logic [35:0] dd, input logic [17:0] dv,
                                output logic [17:0] q, output logic [17:0] r,
                                output logic o, output logic z);
    longint sd, sv, lq, lr;
    sd = longint'($signed(dd));
    sv = longint'($signed(dv));
    o = 1'b0;
    z = 1'b0;
    if (sv == 0) begin
      z = 1'b1;
      q = 18'h3FFFF;
      r = dd[17:0];
    end else begin
      lq = sd / sv;
      lr = sd % sv;
      if (lq > 131071 || lq < -131072) begin
        o = 1'b1;
        q = (lq > 0) ? 18'h1FFFF : 18'h20000;
        r = 18'd0;
      end else begin
        q = lq[17:0];
        r = lr[17:0];
      end
    end
  endfunction

  task automatic do_op(input logic [35:0] dd, input logic [17:0] dv,
                       input int stall, input int hold, input string tag);
    logic [17:0] eq, er;
    logic        eo, ez;
    int          cyc;
    model(dd, dv, eq, er, eo, ez);
    @(negedge clk);
    check({tag, "_in_ready_idle"}, bus.in_ready, 1'b1);
    en           = 1'b1;
    bus.in_valid = 1'b1;
    bus.dividend = dd;
    bus.divisor  = dv;
    @(negedge clk);
    bus.in_valid = 1'b0;
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 200) begin
      en = !(cyc >= 5 && cyc < 5 + stall);
      @(negedge clk);
      cyc++;
    end
    en = 1'b1;
    check({tag, "_latency"}, cyc, 20 + stall);
    check({tag, "_quot"}, bus.quot, eq);
    check({tag, "_rem"},  bus.rem,  er);
    check({tag, "_ovf"},  bus.ovf,  eo);
    check({tag, "_dz"},   bus.dz,   ez);
    check({tag, "_in_ready_busy"}, bus.in_ready, 1'b0);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.dividend = {4'($urandom), 32'($urandom)};
      bus.divisor  = 18'($urandom);
      en           = (i % 2 == 1);
      @(negedge clk);
      check({tag, "_hold_quot"},  bus.quot, eq);
      check({tag, "_hold_rem"},   bus.rem,  er);
      check({tag, "_hold_valid"}, bus.out_valid, 1'b1);
      check({tag, "_hold_ready"}, bus.in_ready,  1'b0);
    end
    bus.in_valid  = 1'b0;
    en            = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_consumed_valid"}, bus.out_valid, 1'b0);
    check({tag, "_consumed_ready"}, bus.in_ready,  1'b1);
  endtask

  initial begin
    logic signed [31:0] s;
    logic [35:0]        dd;
    logic [17:0]        dv;
    int                 cyc;

    rst_n         = 1'b0;
    en            = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready",  bus.in_ready,  1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_quot",      bus.quot,      18'd0);
    check("rst_rem",       bus.rem,       18'd0);
    check("rst_ovf",       bus.ovf,       1'b0);
    check("rst_dz",        bus.dz,        1'b0);
    rst_n = 1'b1;
    en    = 1'b1;

    do_op(36'd100, 18'd7, 0, 0, "pos_pos");
    do_op(-36'sd100, 18'd7, 0, 0, "neg_pos");
    do_op(36'd100, -18'sd7, 0, 0, "pos_neg");
    do_op(-36'sd100, -18'sd7, 0, 0, "neg_neg");
    do_op(36'd5, 18'd0, 0, 0, "div_zero");
    do_op(-36'sd5, 18'd0, 0, 0, "div_zero_neg");
    do_op(36'd1 << 30, 18'd1, 0, 0, "ovf_pos");
    do_op(-36'sd131072, 18'd1, 0, 0, "min_quot");
    do_op(36'd131072, -18'sd1, 0, 0, "min_quot_neg_dv");
    do_op(36'd131072, 18'd1, 0, 0, "ovf_edge_pos");
    do_op(-36'sd131073, 18'd1, 0, 0, "ovf_edge_neg");
    do_op(36'h800000000, -18'sd1, 0, 0, "ovf_most_neg");
    do_op(36'h800000000, 18'h20000, 0, 0, "most_neg_by_most_neg");
    do_op(36'd1000, 18'd7, 5, 10, "stall_hold");

    // Abort an operation partway through CALC with a synchronous reset.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.dividend = 36'd1000;
    bus.divisor  = 18'd3;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_in_ready",  bus.in_ready,  1'b1);
    check("abort_out_valid", bus.out_valid, 1'b0);
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 25) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_no_result", bus.out_valid, 1'b0);
    do_op(36'd9, 18'd3, 0, 0, "after_abort");

    for (int i = 0; i < 40; i++) begin
      s = $urandom;
      if (i % 4 == 0) dd = {4'($urandom), 32'($urandom)};
      else            dd = 36'(s >>> $urandom_range(0, 20));
      if (i % 3 == 0) begin
        dv = 18'($urandom_range(0, 40));
        if ($urandom_range(0, 1) == 1) dv = -dv;
      end else begin
        dv = 18'($urandom);
      end
      do_op(dd, dv, $urandom_range(0, 3), $urandom_range(0, 2), "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
